sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Memory-side controller directly downstream of the MEM stage of the 5-stage ARM pipeline.
- Converts the 32-bit word load/store requests issued by the MEM stage into two sequential 16-bit accesses to an external asynchronous SRAM.
- Holds `ready` low while busy, so the hazard/freeze logic stalls every pipeline register until the access completes.

Parameters:
- WAIT_CYCLES, 2, cycles each 16-bit half-access is held on the SRAM bus (minimum 1).
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- SRAM_AW, 18, SRAM halfword address width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-high
- rd_en  in  1  load request from MEM stage (MEM_R_EN)
- wr_en  in  1  store request from MEM stage (MEM_W_EN)
- address  in  32  byte address (alu_res)
- write_data  in  32  store data (rm_val)
- read_data  out  32  assembled load data, registered
- ready  out  1  1 = no access pending or access finishing this cycle; 0 = freeze pipeline
- sram_addr  out  SRAM_AW  halfword address
- sram_dq_out  out  16  write data to SRAM
- sram_dq_oe  out  1  1 = drive sram_dq_out onto the bus
- sram_dq_in  in  16  read data from SRAM
- sram_we_n  out  1  write strobe, active-low

Behaviour:
- Reset (async, rst=1) sets:
  - state=IDLE, counter=0, read_data=0.
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - ready follows its combinational rule from the IDLE state.
- Reset mid-transaction aborts the access immediately; no partial SRAM write continues after rst rises.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits.
  - low half: sram_addr = {word, 1'b0}; high half: sram_addr = {word, 1'b1}.
  - address[1:0] is ignored.
- Request: req = rd_en | wr_en. If both are asserted, the access is a write.
- Requests are sampled only in IDLE. Address, data and direction are latched on the IDLE->LOW edge. Inputs are then ignored until the state returns to IDLE.
- ready (combinational):
  - 1 in IDLE when req=0.
  - 0 in IDLE when req=1.
  - 0 in LOW and HIGH.
  - 1 in DONE.
- State machine:
  - IDLE: req -> LOW, counter=0.
  - LOW: drives the low half. When counter == WAIT_CYCLES-1 -> HIGH, counter=0; otherwise counter+1.
  - HIGH: drives the high half. When counter == WAIT_CYCLES-1 -> DONE; otherwise counter+1.
  - DONE: ready=1 for exactly one cycle, then -> IDLE unconditionally.
- Latency: with req first seen in IDLE at cycle 0, ready=1 in cycle 2*WAIT_CYCLES+1. The pipeline advances on the edge that ends that cycle.
- Back-to-back requests: the request still present in the cycle after DONE is sampled as a new request. There is at least one IDLE cycle between accesses, and ready=0 in that cycle.
- Write timing:
  - sram_dq_oe=1 and sram_we_n=0 for all cycles of LOW and HIGH.
  - sram_dq_out = write_data[15:0] in LOW, write_data[31:16] in HIGH.
  - sram_we_n rises at DONE.
- Read timing:
  - sram_dq_oe=0 and sram_we_n=1 throughout.
  - sram_dq_in is captured into read_data[15:0] at the last LOW cycle and into read_data[31:16] at the last HIGH cycle.
  - read_data is stable from DONE until the next read's capture.
  - Writes do not modify read_data.
- Request deasserted mid-access: the access still completes, and ready=1 in DONE regardless.
- SRAM outputs are registered (no combinational path from rd_en/wr_en to sram_*).
- ready has a combinational path from rd_en/wr_en in IDLE only.

Optional Feature:
- Macro: SRAM_RANGE_CHECK_EN.
- Defined:
  - An address below BASE_ADDR, or at/above BASE_ADDR + 2^(SRAM_AW+1), skips LOW/HIGH and goes IDLE -> DONE.
  - No SRAM strobes are issued.
  - read_data is set to 0 on a read.
  - Extra output range_err (1 bit, reset 0) pulses high for the DONE cycle.
- Undefined: no range_err port. Every address is mapped by truncation, and out-of-range accesses alias into the SRAM.

Decomposition:
- Shared package sram_pkg holds:
  - state typedef (IDLE, LOW, HIGH, DONE, 2-bit).
  - constants SRAM_DW=16 and WORD_W=32.
  - default BASE_ADDR.
- One natural sub-module: sram_addr_map (combinational byte-address -> halfword-address translation, plus range check under the macro). It is reused by the SRAM behavioural model in the bench.

Test Plan:
- Reset: assert rst mid-LOW of a write -> within the same cycle sram_we_n=1, sram_dq_oe=0, read_data=0; after release ready=1 with req=0.
- Store: WAIT_CYCLES=2, wr_en=1, address=1024+8, write_data=0xDEADBEEF -> SRAM halfword 4 gets 0xBEEF, halfword 5 gets 0xDEAD; ready=1 exactly in cycle 5.
- Load: preload halfwords 4/5 = 0x1234/0xABCD, rd_en=1, address=1032 -> read_data=0xABCD1234 in cycle 5 and held after.
- Back-to-back: store then load to the same address with request held -> second access begins after one IDLE cycle; load returns the stored value; ready low except the two DONE cycles.
- Simultaneous rd_en=wr_en=1, write_data=0x55AA00FF -> treated as write; read_data unchanged.
- Range check (SRAM_RANGE_CHECK_EN): rd_en=1, address=4 -> no sram_we_n/oe activity, ready=1 in cycle 1, range_err=1 for one cycle, read_data=0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM controller and its address map.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int SRAM_DW = 16;
    localparam int WORD_W  = 32;

    localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_addr_map.sv
// Byte address -> SRAM word index translation.
// With SRAM_RANGE_CHECK_EN defined, also flags addresses outside the SRAM window.
module sram_addr_map
    import sram_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int                SRAM_AW   = 18
) (
    input  logic [WORD_W-1:0]  addr_i,
    output logic [SRAM_AW-2:0] word_o
`ifdef SRAM_RANGE_CHECK_EN
    ,
    output logic               in_range_o
`endif
);

    logic [WORD_W-1:0] offset;

    assign offset = addr_i - BASE_ADDR;

    // Byte offset bits [1:0] are dropped; the word index is truncated to SRAM_AW-1 bits,
    // leaving room for the half-select bit appended by the controller.
    assign word_o = offset[SRAM_AW:2];

`ifdef SRAM_RANGE_CHECK_EN
    // In range when at/above the base and the offset fits in 2^(SRAM_AW+1) bytes.
    assign in_range_o = (addr_i >= BASE_ADDR) && (offset[WORD_W-1:SRAM_AW+1] == '0);
`else
    // Upper offset bits only matter for the range check; out-of-range addresses alias.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[WORD_W-1:SRAM_AW+1]};
`endif

    logic unused_byte_bits;
    assign unused_byte_bits = ^offset[1:0];

endmodule

// File: rtl/sram_ctrl.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit asynchronous SRAM accesses
// (low half then high half) and holds ready low until the access finishes.
// Optional macro: SRAM_RANGE_CHECK_EN adds an address window check and a range_err output.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int                WAIT_CYCLES = 2,
    parameter logic [WORD_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int                SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [WORD_W-1:0]  address,
    input  logic [WORD_W-1:0]  write_data,
    output logic [WORD_W-1:0]  read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n
`ifdef SRAM_RANGE_CHECK_EN
    ,
    output logic               range_err
`endif
);

    localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SRAM_AW-2:0] word_q, word_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic               is_wr_q, is_wr_d;
    logic [WORD_W-1:0]  read_data_q, read_data_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [SRAM_DW-1:0] dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
    logic               we_n_q, we_n_d;
    logic               req;
    logic               drive;
    logic [SRAM_AW-2:0] map_word;

`ifdef SRAM_RANGE_CHECK_EN
    logic               in_range;
    logic               range_err_q, range_err_d;
`endif

    sram_addr_map #(
        .BASE_ADDR (BASE_ADDR),
        .SRAM_AW   (SRAM_AW)
    ) u_addr_map (
        .addr_i     (address),
        .word_o     (map_word)
`ifdef SRAM_RANGE_CHECK_EN
        ,
        .in_range_o (in_range)
`endif
    );

    assign req = rd_en | wr_en;

    // Next-state, latched request fields, read capture and ready.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        read_data_d = read_data_q;
        ready       = 1'b0;

        case (state_q)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    word_d  = map_word;
                    wdata_d = write_data;
                    is_wr_d = wr_en;
                    cnt_d   = '0;
`ifdef SRAM_RANGE_CHECK_EN
                    if (!in_range) begin
                        state_d = DONE;
                        if (!wr_en) read_data_d = '0;
                    end else begin
                        state_d = LOW;
                    end
`else
                    state_d = LOW;
`endif
                end
            end
            LOW: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    if (!is_wr_q) read_data_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    if (!is_wr_q) read_data_d[31:16] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // SRAM bus values for the upcoming cycle, derived from the next state so the pins are registered.
    always_comb begin
        drive       = (state_d == LOW) || (state_d == HIGH);
        sram_addr_d = drive ? {word_d, (state_d == HIGH)} : '0;
        dq_oe_d     = drive && is_wr_d;
        we_n_d      = ~(drive && is_wr_d);
        dq_out_d    = '0;
        if (drive && is_wr_d) dq_out_d = (state_d == HIGH) ? wdata_d[31:16] : wdata_d[15:0];
    end

`ifdef SRAM_RANGE_CHECK_EN
    // The only IDLE->DONE transition is a rejected out-of-range access.
    assign range_err_d = (state_q == IDLE) && (state_d == DONE);
`endif

    // State and output registers; reset aborts any access and releases the bus at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
`ifdef SRAM_RANGE_CHECK_EN
            range_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
`ifdef SRAM_RANGE_CHECK_EN
            range_err_q <= range_err_d;
`endif
        end
    end

    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
`ifdef SRAM_RANGE_CHECK_EN
    assign range_err   = range_err_q;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl with a behavioural asynchronous SRAM.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;
`ifdef SRAM_RANGE_CHECK_EN
    logic        range_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_ctrl #(
        .WAIT_CYCLES (2),
        .BASE_ADDR   (32'd1024),
        .SRAM_AW     (18)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
`ifdef SRAM_RANGE_CHECK_EN
        ,
        .range_err   (range_err)
`endif
    );

    // Behavioural asynchronous SRAM with a bench-side preload port.
    logic [15:0] mem [0:(1<<18)-1];
    logic        pre_en = 1'b0;
    logic [17:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en)          mem[pre_addr]  <= pre_data;
        else if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
    end

    assign sram_dq_in = mem[sram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;

        // Reset values
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_we_n",  32'(sram_we_n),   32'd1);
        check("rst_oe",    32'(sram_dq_oe),  32'd0);
        check("rst_rdata", read_data,        32'd0);
        check("rst_addr",  32'(sram_addr),   32'd0);
        check("rst_dqout", 32'(sram_dq_out), 32'd0);
        check("rst_ready_idle", 32'(ready),  32'd1);
`ifdef SRAM_RANGE_CHECK_EN
        check("rst_range_err", 32'(range_err), 32'd0);
`endif

        // Store 0xDEADBEEF at 1032 -> halfwords 4/5; request dropped after cycle 0
        wr_en = 1'b1; address = 32'd1032; write_data = 32'hDEADBEEF;
        #1;
        check("st_ready_c0", 32'(ready), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) wr_en = 1'b0;
            check($sformatf("st_ready_c%0d", c), 32'(ready), 32'(c == 5));
            if (c <= 4) begin
                check($sformatf("st_we_n_c%0d", c), 32'(sram_we_n),  32'd0);
                check($sformatf("st_oe_c%0d", c),   32'(sram_dq_oe), 32'd1);
                check($sformatf("st_addr_c%0d", c), 32'(sram_addr),  (c <= 2) ? 32'd4 : 32'd5);
                check($sformatf("st_dq_c%0d", c),   32'(sram_dq_out), (c <= 2) ? 32'h0000BEEF : 32'h0000DEAD);
            end else begin
                check("st_we_n_done", 32'(sram_we_n),  32'd1);
                check("st_oe_done",   32'(sram_dq_oe), 32'd0);
            end
        end
        tick();
        check("st_ready_idle", 32'(ready), 32'd1);
        check("st_mem4", 32'(mem[4]), 32'h0000BEEF);
        check("st_mem5", 32'(mem[5]), 32'h0000DEAD);
        check("st_rdata_untouched", read_data, 32'd0);

        // Load from 1032 after preloading 0x1234 / 0xABCD
        pre_en = 1'b1; pre_addr = 18'd4; pre_data = 16'h1234;
        tick();
        pre_addr = 18'd5; pre_data = 16'hABCD;
        tick();
        pre_en = 1'b0;
        rd_en = 1'b1; address = 32'd1032;
        #1;
        check("ld_ready_c0", 32'(ready), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("ld_ready_c%0d", c), 32'(ready),      32'(c == 5));
            check($sformatf("ld_we_n_c%0d", c),  32'(sram_we_n),  32'd1);
            check($sformatf("ld_oe_c%0d", c),    32'(sram_dq_oe), 32'd0);
            check($sformatf("ld_rdata_c%0d", c), read_data,
                  (c <= 2) ? 32'd0 : (c <= 4) ? 32'h00001234 : 32'hABCD1234);
        end
        rd_en = 1'b0;
        tick();
        check("ld_rdata_hold", read_data, 32'hABCD1234);
        check("ld_ready_idle", 32'(ready), 32'd1);

        // Back-to-back: store then load to 1040 (halfwords 8/9) with the request held
        wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
        #1;
        for (int c = 0; c <= 11; c++) begin
            if (c > 0) tick();
            check($sformatf("b2b_ready_c%0d", c), 32'(ready), 32'(c == 5 || c == 11));
            if (c == 6) check("b2b_gap_we_n", 32'(sram_we_n), 32'd1);
            if (c == 7) check("b2b_rd_addr_lo", 32'(sram_addr), 32'd8);
            if (c == 5) begin
                wr_en = 1'b0;
                rd_en = 1'b1;
            end
        end
        check("b2b_rdata", read_data, 32'hCAFEF00D);
        check("b2b_mem8", 32'(mem[8]), 32'h0000F00D);
        check("b2b_mem9", 32'(mem[9]), 32'h0000CAFE);
        rd_en = 1'b0;
        tick();

        // Simultaneous rd_en/wr_en is a write; read_data untouched
        rd_en = 1'b1; wr_en = 1'b1; address = 32'd1048; write_data = 32'h55AA00FF;
        #1;
        check("both_ready_c0", 32'(ready), 32'd0);
        tick();
        check("both_we_n_c1", 32'(sram_we_n),   32'd0);
        check("both_oe_c1",   32'(sram_dq_oe),  32'd1);
        check("both_dq_c1",   32'(sram_dq_out), 32'h000000FF);
        rd_en = 1'b0; wr_en = 1'b0;
        repeat (4) tick();
        check("both_ready_c5", 32'(ready), 32'd1);
        check("both_rdata",    read_data,  32'hCAFEF00D);
        tick();
        check("both_mem12", 32'(mem[12]), 32'h000000FF);
        check("both_mem13", 32'(mem[13]), 32'h000055AA);

`ifdef SRAM_RANGE_CHECK_EN
        // Out-of-range read: no strobes, done in cycle 1, range_err pulse, read_data cleared
        rd_en = 1'b1; address = 32'd4;
        #1;
        check("rng_ready_c0", 32'(ready), 32'd0);
        tick();
        check("rng_ready_c1", 32'(ready),      32'd1);
        check("rng_err_c1",   32'(range_err),  32'd1);
        check("rng_rdata",    read_data,       32'd0);
        check("rng_we_n",     32'(sram_we_n),  32'd1);
        check("rng_oe",       32'(sram_dq_oe), 32'd0);
        rd_en = 1'b0;
        tick();
        check("rng_err_c2",   32'(range_err),  32'd0);
        check("rng_ready_c2", 32'(ready),      32'd1);
        // Restore non-zero read_data so the reset check below is meaningful
        rd_en = 1'b1; address = 32'd1040;
        tick();
        rd_en = 1'b0;
        repeat (5) tick();
        check("rng_reload", read_data, 32'hCAFEF00D);
`endif

        // Reset in the middle of a write's LOW phase
        wr_en = 1'b1; address = 32'd1056; write_data = 32'h12345678;
        tick();
        check("mid_we_n_active", 32'(sram_we_n), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_we_n",  32'(sram_we_n),   32'd1);
        check("mid_oe",    32'(sram_dq_oe),  32'd0);
        check("mid_rdata", read_data,        32'd0);
        check("mid_addr",  32'(sram_addr),   32'd0);
        check("mid_dqout", 32'(sram_dq_out), 32'd0);
        wr_en = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("mid_ready_after", 32'(ready), 32'd1);
        tick();
        check("mid_ready_idle", 32'(ready),     32'd1);
        check("mid_we_n_idle",  32'(sram_we_n), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
